memcpy_burst_engine: RTL and testbench
======================================

// Module: memcpy_burst_engine
// PURPOSE
//  Parametrised memory-copy engine: splits copies of arbitrary beat-multiple length into read/write bursts
//  (max MAX_BURST beats, never crossing a 4KB boundary). Read and write run decoupled through an internal
//  FIFO. Sits between the action register block and the local memory read/write channels.
// PARAMETERS
//  ADDR_WIDTH  64   byte address width
//  DATA_WIDTH  512  beat width; BEAT = DATA_WIDTH/8 bytes (power of 2)
//  LEN_WIDTH   32   width of memcpy_len (bytes)
//  MAX_BURST   64   max beats per burst, 1..min(255, 4096/BEAT)
//  FIFO_DEPTH  128  data FIFO entries; power of 2, >= MAX_BURST
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           asynchronous reset, active low
//  memcpy_src_addr in ADDR_WIDTH  source byte address, BEAT-aligned
//  memcpy_tgt_addr in ADDR_WIDTH  target byte address, BEAT-aligned
//  memcpy_len    in   LEN_WIDTH   bytes to copy, multiple of BEAT
//  memcpy_start  in   1           1-cycle start pulse; params sampled that cycle
//  memcpy_busy   out  1           copy in progress
//  memcpy_done   out  1           level; set at completion, cleared by next accepted start
//  memcpy_err    out  1           level; misaligned src/tgt/len, set with done
//  lcl_ibusy     in   1           write channel cannot accept istart
//  lcl_istart    out  1           write burst request pulse
//  lcl_iaddr     out  ADDR_WIDTH  write burst start address
//  lcl_inum      out  8           write burst beats (1..MAX_BURST)
//  lcl_irdy      in   1           write channel accepts a beat
//  lcl_den       out  1           write beat valid
//  lcl_din       out  DATA_WIDTH  write beat data
//  lcl_idone     out  1           pulse after last beat of write burst
//  lcl_obusy     in   1           read channel cannot accept ostart
//  lcl_ostart    out  1           read burst request pulse
//  lcl_oaddr     out  ADDR_WIDTH  read burst start address
//  lcl_onum      out  8           read burst beats (1..MAX_BURST)
//  lcl_ordy      in   1           read channel can return a beat
//  lcl_rden      out  1           pull one read beat
//  lcl_dv        in   1           read beat valid
//  lcl_dout      in   DATA_WIDTH  read beat data
//  lcl_odone     in   1           read burst complete
// BEHAVIOUR
//  - Reset: all outputs 0, both FSMs IDLE, FIFO empty, counters 0. Reset mid-copy aborts; no done/err.
//  - Start accepted only when !memcpy_busy; ignored otherwise. Accept clears done/err, sets busy next cycle.
//  - Misaligned (any low log2(BEAT) bit set in src/tgt/len): no bursts; done=err=1, busy=0 one cycle after start.
//  - len==0: no bursts; done=1, err=0 one cycle after start.
//  - Burst size = min(remaining beats, MAX_BURST, beats to next 4KB boundary of current addr); computed
//    independently per side. Address advances by size*BEAT; remaining decrements by size.
//  - Read FSM: IDLE->CALC->WAIT->START->INPROC->(CALC | DONE). WAIT until FIFO free minus reserved >= size.
//    START: lcl_ostart=1 for one cycle when !lcl_obusy; reserve size entries. INPROC: lcl_rden=lcl_ordy until
//    size beats pulled; leave on lcl_odone. Each lcl_dv pushes lcl_dout (reservation converts to occupancy).
//  - Write FSM: IDLE->CALC->WAIT->START->INPROC->DONE->(CALC | IDLE). WAIT until FIFO count >= size.
//    START: lcl_istart=1 one cycle when !lcl_ibusy. INPROC: on lcl_irdy pop; lcl_den/lcl_din registered,
//    1-cycle latency from pop. DONE: lcl_idone=1 one cycle.
//  - FIFO never overflows (reservation) nor underflows (pop only when count>0). Simultaneous push+pop keeps count.
//  - Completion: done=1, busy=0 the cycle after last write-side idone when read side also DONE.
//  - Address arithmetic ADDR_WIDTH modular; wrap past max address not checked.
// CONFIGURATION
//  MEMCPY_PERF_CNT_EN defined: extra output memcpy_cycles[31:0] counts clk from accepted start to done,
//  saturating at 0xFFFFFFFF, held until next start, reset 0. Undefined: port and counter absent, no change otherwise.
// TESTING (BEAT=64B, defaults)
//  1 src=0x1000 tgt=0x8000 len=0x100 -> one ostart onum=4 @0x1000, one istart inum=4 @0x8000, data match, done=1 err=0.
//  2 src=0x0FC0 tgt=0x2000 len=0x200 -> reads onum=1 @0xFC0 then onum=7 @0x1000; one write inum=8 @0x2000.
//  3 src=0 tgt=0x10000 len=0x3000 -> 3 read and 3 write bursts of 64 beats, addresses step 0x1000; done.
//  4 len=0 -> done=1 one cycle after start, no ostart/istart; len=0x1004 -> err=1, done=1, no bursts.
//  5 len=0x4000, lcl_irdy=0 for 500 cycles -> reads stop at 128 buffered beats, no overflow, full data match.
//  6 rst_n low mid-burst of test 3 -> outputs 0 immediately; new start src=0x1000 len=0x100 completes as test 1.

Source files
------------

// File: rtl/memcpy_burst_engine.sv
// memcpy_burst_engine: copies BEAT-multiple regions in <=MAX_BURST, 4KB-safe
// bursts with decoupled read/write FSMs joined by a reserved data FIFO.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   memcpy_*          action-register side: src/tgt/len, start pulse,
//                     busy, done/err levels
//   lcl_i*/den/din    local write channel (burst request + beat stream)
//   lcl_o*/rden/dv    local read channel (burst request + beat pull)
//   memcpy_cycles     copy duration counter, only with MEMCPY_PERF_CNT_EN
//
// Optional build macro: MEMCPY_PERF_CNT_EN
module memcpy_burst_engine #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 32,
  parameter int MAX_BURST  = 64,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] memcpy_src_addr,
  input  logic [ADDR_WIDTH-1:0] memcpy_tgt_addr,
  input  logic [LEN_WIDTH-1:0]  memcpy_len,
  input  logic                  memcpy_start,
  output logic                  memcpy_busy,
  output logic                  memcpy_done,
  output logic                  memcpy_err,
`ifdef MEMCPY_PERF_CNT_EN
  output logic [31:0]           memcpy_cycles,
`endif
  input  logic                  lcl_ibusy,
  output logic                  lcl_istart,
  output logic [ADDR_WIDTH-1:0] lcl_iaddr,
  output logic [7:0]            lcl_inum,
  input  logic                  lcl_irdy,
  output logic                  lcl_den,
  output logic [DATA_WIDTH-1:0] lcl_din,
  output logic                  lcl_idone,
  input  logic                  lcl_obusy,
  output logic                  lcl_ostart,
  output logic [ADDR_WIDTH-1:0] lcl_oaddr,
  output logic [7:0]            lcl_onum,
  input  logic                  lcl_ordy,
  output logic                  lcl_rden,
  input  logic                  lcl_dv,
  input  logic [DATA_WIDTH-1:0] lcl_dout,
  input  logic                  lcl_odone
);

  localparam int BEAT = DATA_WIDTH / 8;
  localparam int BL   = $clog2(BEAT);
  localparam int PB   = 4096 / BEAT;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(BEAT - 1);
  localparam logic [LEN_WIDTH-1:0] LMASK =
    LEN_WIDTH'(BEAT - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_CALC, R_WAIT, R_START, R_INPROC, R_DONE
  } r_state_t;

  typedef enum logic [2:0] {
    W_IDLE, W_CALC, W_WAIT, W_START, W_INPROC, W_DONE
  } w_state_t;

  // min(remaining, MAX_BURST, beats left in the current 4KB page)
  function automatic logic [7:0] burst_size(
    input logic [11:0]          a,
    input logic [LEN_WIDTH-1:0] rem
  );
    logic [12:0] room;
    logic [12:0] sz;
    room = 13'(PB) - ({1'b0, a} >> BL);
    sz   = 13'(MAX_BURST);
    if (room < sz) sz = room;
    if (rem < LEN_WIDTH'(sz)) sz = 13'(rem);
    return 8'(sz);
  endfunction

  r_state_t r_state;
  w_state_t w_state;

  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [LEN_WIDTH-1:0]  r_rem, w_rem;
  logic [7:0]            r_size, w_size;
  logic [7:0]            r_pulled, w_popped;
  logic                  w_ack;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wp, rp;
  logic [CW-1:0]         f_cnt, f_rsv, f_free, rsv_add;

  logic start_acc, misal, zero_len, go, fin;
  logic push, pop, r_accept, rsv_dec;

  assign start_acc = memcpy_start && !memcpy_busy;
  assign misal     = |(memcpy_src_addr & AMASK) ||
                     |(memcpy_tgt_addr & AMASK) ||
                     |(memcpy_len & LMASK);
  assign zero_len  = memcpy_len == '0;
  assign go        = start_acc && !misal && !zero_len;

  assign fin = (w_state == W_DONE) && w_ack &&
               (w_rem == '0) && (r_state == R_DONE);

  assign r_accept = (r_state == R_START) && !lcl_obusy;
  assign rsv_add  = r_accept ? CW'(r_size) : '0;
  assign f_free   = CW'(FIFO_DEPTH) - f_cnt - f_rsv;

  assign lcl_rden = (r_state == R_INPROC) && lcl_ordy &&
                    (r_pulled != r_size);

  // Space for every in-flight beat is reserved before ostart,
  // so the count guard here never blocks a legal dv.
  assign push    = lcl_dv && (f_cnt != CW'(FIFO_DEPTH));
  assign rsv_dec = push && (f_rsv != '0);
  assign pop     = (w_state == W_INPROC) && lcl_irdy &&
                   (w_popped != w_size) && (f_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memcpy_busy <= 1'b0;
      memcpy_done <= 1'b0;
      memcpy_err  <= 1'b0;
    end else begin
      unique case (1'b1)
        start_acc: begin
          memcpy_busy <= go;
          memcpy_done <= misal || zero_len;
          memcpy_err  <= misal;
        end
        fin: begin
          memcpy_busy <= 1'b0;
          memcpy_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MEMCPY_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memcpy_cycles <= '0;
    end else if (start_acc) begin
      memcpy_cycles <= 32'd1;
    end else if (memcpy_busy && memcpy_cycles != '1) begin
      memcpy_cycles <= memcpy_cycles + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_size     <= '0;
      r_pulled   <= '0;
      lcl_ostart <= 1'b0;
      lcl_oaddr  <= '0;
      lcl_onum   <= '0;
    end else begin
      lcl_ostart <= 1'b0;
      unique case (r_state)
        R_IDLE: begin
          if (go) begin
            r_addr  <= memcpy_src_addr;
            r_rem   <= memcpy_len >> BL;
            r_state <= R_CALC;
          end
        end
        R_CALC: begin
          r_size  <= burst_size(r_addr[11:0], r_rem);
          r_state <= R_WAIT;
        end
        R_WAIT: begin
          if (f_free >= CW'(r_size)) r_state <= R_START;
        end
        R_START: begin
          if (r_accept) begin
            lcl_ostart <= 1'b1;
            lcl_oaddr  <= r_addr;
            lcl_onum   <= r_size;
            r_addr     <= r_addr +
                          (ADDR_WIDTH'(r_size) << BL);
            r_rem      <= r_rem - LEN_WIDTH'(r_size);
            r_pulled   <= '0;
            r_state    <= R_INPROC;
          end
        end
        R_INPROC: begin
          if (lcl_rden) r_pulled <= r_pulled + 8'd1;
          if (lcl_odone) begin
            r_state <= (r_rem == '0) ? R_DONE : R_CALC;
          end
        end
        R_DONE: begin
          if (fin) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state    <= W_IDLE;
      w_addr     <= '0;
      w_rem      <= '0;
      w_size     <= '0;
      w_popped   <= '0;
      w_ack      <= 1'b0;
      lcl_istart <= 1'b0;
      lcl_iaddr  <= '0;
      lcl_inum   <= '0;
      lcl_idone  <= 1'b0;
    end else begin
      lcl_istart <= 1'b0;
      lcl_idone  <= 1'b0;
      unique case (w_state)
        W_IDLE: begin
          if (go) begin
            w_addr  <= memcpy_tgt_addr;
            w_rem   <= memcpy_len >> BL;
            w_state <= W_CALC;
          end
        end
        W_CALC: begin
          w_size  <= burst_size(w_addr[11:0], w_rem);
          w_state <= W_WAIT;
        end
        W_WAIT: begin
          if (f_cnt >= CW'(w_size)) w_state <= W_START;
        end
        W_START: begin
          if (!lcl_ibusy) begin
            lcl_istart <= 1'b1;
            lcl_iaddr  <= w_addr;
            lcl_inum   <= w_size;
            w_addr     <= w_addr +
                          (ADDR_WIDTH'(w_size) << BL);
            w_rem      <= w_rem - LEN_WIDTH'(w_size);
            w_popped   <= '0;
            w_state    <= W_INPROC;
          end
        end
        W_INPROC: begin
          if (pop) begin
            w_popped <= w_popped + 8'd1;
            if (w_popped + 8'd1 == w_size) w_state <= W_DONE;
          end
        end
        W_DONE: begin
          // first cycle lets the last den drain, second
          // carries idone; then move on or wait for reads
          if (!w_ack) begin
            lcl_idone <= 1'b1;
            w_ack     <= 1'b1;
          end else if (w_rem != '0) begin
            w_ack   <= 1'b0;
            w_state <= W_CALC;
          end else if (fin) begin
            w_ack   <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= lcl_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      f_cnt   <= '0;
      f_rsv   <= '0;
      lcl_den <= 1'b0;
      lcl_din <= '0;
    end else begin
      lcl_den <= pop;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp      <= rp + 1'b1;
        lcl_din <= mem[rp];
      end
      f_cnt <= f_cnt + CW'(push) - CW'(pop);
      f_rsv <= f_rsv + rsv_add - CW'(rsv_dec);
    end
  end

endmodule

// File: tb/tb_memcpy_burst_engine.sv
// tb_memcpy_burst_engine: table-driven copies against a read/write
// memory model with burst and data scoreboards.
module tb_memcpy_burst_engine;

  localparam int DW = 512;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  num;
  } bst_t;

  typedef struct {
    logic [63:0] src;
    logic [63:0] tgt;
    logic [31:0] len;
    bit          err;
    int          nrd;
    int          nwr;
    bit          rnd;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   memcpy_src_addr = '0;
  logic [63:0]   memcpy_tgt_addr = '0;
  logic [31:0]   memcpy_len = '0;
  logic          memcpy_start = 1'b0;
  logic          memcpy_busy, memcpy_done, memcpy_err;
  logic          lcl_ibusy = 1'b0;
  logic          lcl_istart;
  logic [63:0]   lcl_iaddr;
  logic [7:0]    lcl_inum;
  logic          lcl_irdy = 1'b0;
  logic          lcl_den;
  logic [DW-1:0] lcl_din;
  logic          lcl_idone;
  logic          lcl_obusy = 1'b0;
  logic          lcl_ostart;
  logic [63:0]   lcl_oaddr;
  logic [7:0]    lcl_onum;
  logic          lcl_ordy = 1'b0;
  logic          lcl_rden;
  logic          lcl_dv = 1'b0;
  logic [DW-1:0] lcl_dout = '0;
  logic          lcl_odone = 1'b0;

  memcpy_burst_engine dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .memcpy_src_addr (memcpy_src_addr),
    .memcpy_tgt_addr (memcpy_tgt_addr),
    .memcpy_len      (memcpy_len),
    .memcpy_start    (memcpy_start),
    .memcpy_busy     (memcpy_busy),
    .memcpy_done     (memcpy_done),
    .memcpy_err      (memcpy_err),
    .lcl_ibusy       (lcl_ibusy),
    .lcl_istart      (lcl_istart),
    .lcl_iaddr       (lcl_iaddr),
    .lcl_inum        (lcl_inum),
    .lcl_irdy        (lcl_irdy),
    .lcl_den         (lcl_den),
    .lcl_din         (lcl_din),
    .lcl_idone       (lcl_idone),
    .lcl_obusy       (lcl_obusy),
    .lcl_ostart      (lcl_ostart),
    .lcl_oaddr       (lcl_oaddr),
    .lcl_onum        (lcl_onum),
    .lcl_ordy        (lcl_ordy),
    .lcl_rden        (lcl_rden),
    .lcl_dv          (lcl_dv),
    .lcl_dout        (lcl_dout),
    .lcl_odone       (lcl_odone)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  bst_t          exp_rd[$];
  bst_t          exp_wr[$];
  logic [DW-1:0] exp_data[$];
  logic [63:0]   pend[$];

  bit          rnd = 1'b0;
  bit          irdy_en = 1'b1;
  logic [63:0] rd_addr = '0;
  int          deliv_left = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  int          idone_cnt = 0;
  int          idone_cyc = 0;
  int          pulled = 0;

  vec_t vt[7];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    return {8{a ^ 64'hC3A5_9600_0000_0000}};
  endfunction

  function automatic void split(input logic [63:0] a,
                                input logic [31:0] len,
                                input bit rd);
    int   beats, room, n;
    bst_t b;
    beats = int'(len / 64);
    while (beats > 0) begin
      room = (4096 - int'(a % 64'd4096)) / 64;
      n = beats;
      if (n > 64) n = 64;
      if (room < n) n = room;
      b.addr = a;
      b.num  = 8'(n);
      if (rd) exp_rd.push_back(b);
      else exp_wr.push_back(b);
      a = a + 64'(n * 64);
      beats = beats - n;
    end
  endfunction

  // read channel: data returns the cycle after each pull,
  // odone rides along with the last beat of a burst
  always @(negedge clk) begin
    bst_t e;
    lcl_dv = 1'b0;
    lcl_odone = 1'b0;
    if (pend.size() > 0) begin
      lcl_dv = 1'b1;
      lcl_dout = pat(pend.pop_front());
      deliv_left--;
      if (deliv_left == 0) lcl_odone = 1'b1;
    end
    lcl_ordy = !rnd || ($urandom_range(2) != 0);
    #1;
    if (lcl_ostart) begin
      rd_seen++;
      e = '{addr: '1, num: 8'd0};
      if (exp_rd.size() > 0) e = exp_rd.pop_front();
      chk("oaddr", lcl_oaddr, e.addr);
      chk("onum", 64'(lcl_onum), 64'(e.num));
      rd_addr = lcl_oaddr;
      deliv_left = int'(lcl_onum);
    end
    if (lcl_rden) begin
      pend.push_back(rd_addr);
      rd_addr += 64'd64;
      pulled++;
    end
  end

  always @(negedge clk) begin
    bst_t          e;
    logic [DW-1:0] d;
    lcl_irdy = irdy_en && (!rnd || $urandom_range(3) != 0);
    if (lcl_istart) begin
      wr_seen++;
      e = '{addr: '1, num: 8'd0};
      if (exp_wr.size() > 0) e = exp_wr.pop_front();
      chk("iaddr", lcl_iaddr, e.addr);
      chk("inum", 64'(lcl_inum), 64'(e.num));
    end
    if (lcl_den) begin
      d = '1;
      if (exp_data.size() > 0) d = exp_data.pop_front();
      chkd("din", lcl_din, d);
    end
    if (lcl_idone) begin
      idone_cnt++;
      idone_cyc = cyc;
    end
  end

  task automatic flush();
    pend.delete();
    exp_rd.delete();
    exp_wr.delete();
    exp_data.delete();
    deliv_left = 0;
  endtask

  task automatic start_copy(input vec_t v);
    bit quick;
    quick = v.err || (v.len == 0);
    rnd = v.rnd;
    rd_seen = 0;
    wr_seen = 0;
    idone_cnt = 0;
    pulled = 0;
    if (!quick) begin
      split(v.src, v.len, 1'b1);
      split(v.tgt, v.len, 1'b0);
      for (int i = 0; i < int'(v.len / 64); i++)
        exp_data.push_back(pat(v.src + 64'(i * 64)));
    end
    @(negedge clk);
    memcpy_src_addr = v.src;
    memcpy_tgt_addr = v.tgt;
    memcpy_len = v.len;
    memcpy_start = 1'b1;
    @(negedge clk);
    memcpy_start = 1'b0;
    chk("busy_after_start", 64'(memcpy_busy), 64'(!quick));
    chk("done_after_start", 64'(memcpy_done), 64'(quick));
    chk("err_after_start", 64'(memcpy_err), 64'(v.err));
  endtask

  task automatic finish_copy(input vec_t v);
    bit quick;
    quick = v.err || (v.len == 0);
    if (!quick) begin
      for (int i = 0; i < 6000 && !memcpy_done; i++)
        @(negedge clk);
      chk("done_end", 64'(memcpy_done), 64'd1);
      chk("done_lat", 64'(cyc - idone_cyc), 64'd1);
    end
    chk("busy_end", 64'(memcpy_busy), 64'd0);
    chk("err_end", 64'(memcpy_err), 64'(v.err));
    repeat (3) @(negedge clk);
    chk("n_rd", 64'(rd_seen), 64'(v.nrd));
    chk("n_wr", 64'(wr_seen), 64'(v.nwr));
    chk("n_idone", 64'(idone_cnt), 64'(v.nwr));
    chk("data_left", 64'(exp_data.size()), 64'd0);
    chk("rd_left", 64'(exp_rd.size()), 64'd0);
    chk("wr_left", 64'(exp_wr.size()), 64'd0);
    chk("done_hold", 64'(memcpy_done), 64'd1);
    rnd = 1'b0;
  endtask

  initial begin
    vec_t v5;
    vt[0] = '{64'h1000, 64'h8000, 32'h100, 1'b0, 1, 1, 1'b0};
    vt[1] = '{64'h0FC0, 64'h2000, 32'h200, 1'b0, 2, 1, 1'b0};
    vt[2] = '{64'h0, 64'h10000, 32'h3000, 1'b0, 3, 3, 1'b0};
    vt[3] = '{64'h3000, 64'h5000, 32'h0, 1'b0, 0, 0, 1'b0};
    vt[4] = '{64'h1000, 64'h2000, 32'h1004, 1'b1, 0, 0, 1'b0};
    vt[5] = '{64'h1008, 64'h2000, 32'h40, 1'b1, 0, 0, 1'b0};
    vt[6] = '{64'h7F80, 64'h9FC0, 32'h1000, 1'b0, 2, 2, 1'b1};
    v5    = '{64'h20000, 64'h40000, 32'h4000, 1'b0, 4, 4, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outs",
        64'({memcpy_busy, memcpy_done, memcpy_err, lcl_ostart,
             lcl_istart, lcl_rden, lcl_den, lcl_idone}), 64'd0);
    chk("reset_addr", lcl_oaddr | lcl_iaddr, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_copy(vt[i]);
      finish_copy(vt[i]);
    end

    // write side stalled: reads must stop at a full FIFO
    irdy_en = 1'b0;
    start_copy(v5);
    repeat (100) @(negedge clk);
    memcpy_src_addr = 64'h0;
    memcpy_len = 32'h40;
    memcpy_start = 1'b1;
    @(negedge clk);
    memcpy_start = 1'b0;
    repeat (400) @(negedge clk);
    chk("stall_pulled", 64'(pulled), 64'd128);
    chk("stall_rd_bursts", 64'(rd_seen), 64'd2);
    chk("stall_busy", 64'(memcpy_busy), 64'd1);
    chk("stall_done", 64'(memcpy_done), 64'd0);
    irdy_en = 1'b1;
    finish_copy(v5);

    // async reset in the middle of a multi-burst copy
    start_copy(vt[2]);
    for (int i = 0; i < 3000 && wr_seen == 0; i++)
      @(negedge clk);
    chk("t6_wr_started", 64'(wr_seen), 64'd1);
    repeat (10) @(negedge clk);
    chk("t6_busy", 64'(memcpy_busy), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs",
        64'({memcpy_busy, memcpy_done, memcpy_err, lcl_ostart,
             lcl_istart, lcl_rden, lcl_den, lcl_idone}), 64'd0);
    repeat (2) @(negedge clk);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    start_copy(vt[0]);
    finish_copy(vt[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
